// File: rtl/isa_pkg.sv
// Shared ISA decode table: opcode classes, immediate field widths and a fit check.
// The ID-stage sign extender decodes against this same table.
package isa_pkg;

  localparam logic [3:0] OP_B0 = 4'b1000;
  localparam logic [3:0] OP_B1 = 4'b1011;
  localparam logic [3:0] OP_C0 = 4'b0100;
  localparam logic [3:0] OP_C1 = 4'b0101;
  localparam logic [3:0] OP_C2 = 4'b0110;
  localparam logic [3:0] OP_D0 = 4'b1100;
  localparam logic [3:0] OP_D1 = 4'b1111;

  typedef enum logic [1:0] {TYPE_B, TYPE_C, TYPE_D, TYPE_R} instr_type_e;

  typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_FULL} pack_state_e;

  function automatic instr_type_e op_type(input logic [3:0] opcode);
    case (opcode)
      OP_B0, OP_B1:        return TYPE_B;
      OP_C0, OP_C1, OP_C2: return TYPE_C;
      OP_D0, OP_D1:        return TYPE_D;
      default:             return TYPE_R;
    endcase
  endfunction

  function automatic int unsigned imm_width(input instr_type_e itype);
    case (itype)
      TYPE_C:  return 8;
      TYPE_D:  return 12;
      default: return 4;
    endcase
  endfunction

  // True when sign-extending the low 'width' bits reproduces the full immediate.
  function automatic logic imm_fits(input logic [15:0] imm, input int unsigned width);
    logic signed [15:0] full_val;
    logic signed [15:0] sext;
    full_val = imm;
    sext     = full_val <<< (16 - width);
    sext     = sext >>> (16 - width);
    return sext == full_val;
  endfunction

endpackage

// File: rtl/imm_field_pack.sv
// Combinational packer: opcode, fields and signed immediate -> 16-bit word plus legality.
// Zero latency; no flow control of its own.
module imm_field_pack
  import isa_pkg::*;
(
  input  logic [3:0]  opcode,
  input  logic [3:0]  one,
  input  logic [3:0]  two,
  input  logic [15:0] imm,
  output logic [15:0] word,
  output logic        legal
);

  instr_type_e itype;

  assign itype = op_type(opcode);

  always_comb begin
    case (itype)
      TYPE_C:  word = {opcode, one, imm[7:0]};
      TYPE_D:  word = {opcode, imm[11:0]};
      default: word = {opcode, one, two, imm[3:0]};
    endcase
  end

  // R-type low nibble is a plain register field, so any value is accepted.
  assign legal = (itype == TYPE_R) || imm_fits(imm, imm_width(itype));

endmodule

// File: rtl/instr_word_packer.sv
// Packs requests into instruction words and writes them to IMEM; legal accept -> mem_we next cycle.
// Held word stalls on mem_ready=0; in_ready drops while stalled, when full, or during clear.
module instr_word_packer
  import isa_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_opcode,
  input  logic [3:0]        in_one,
  input  logic [3:0]        in_two,
  input  logic [15:0]       in_imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic              mem_ready,
  output logic              full,
  output logic              err,
  output logic [3:0]        err_op,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  pack_state_e       state_q, state_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [15:0]       mem_wdata_q, mem_wdata_d;
  logic              err_q, err_d;
  logic [3:0]        err_op_q, err_op_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

  logic [15:0] packed_word;
  logic        packed_legal;
  logic        last_held;
  logic        accept;
  logic        wr_done;

  imm_field_pack u_pack (
    .opcode (in_opcode),
    .one    (in_one),
    .two    (in_two),
    .imm    (in_imm),
    .word   (packed_word),
    .legal  (packed_legal)
  );

  // A word replacing the one held at the last address could never be written, so refuse it.
  assign last_held = (state_q == ST_HOLD) && (mem_addr_q == ADDR_MAX);
  assign in_ready  = !clear && (state_q != ST_FULL) &&
                     ((state_q == ST_IDLE) || (mem_ready && !last_held));
  assign accept    = in_valid && in_ready;
  assign wr_done   = mem_we_q && mem_ready;

  always_comb begin
    state_d     = state_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    err_d       = err_q;
    err_op_d    = err_op_q;
    err_cnt_d   = err_cnt_q;

    if (wr_done) begin
      mem_we_d = 1'b0;
      if (mem_addr_q == ADDR_MAX) begin
        state_d = ST_FULL;
      end else begin
        state_d    = ST_IDLE;
        mem_addr_d = mem_addr_q + ADDR_W'(1);
      end
    end

    if (accept) begin
      if (packed_legal) begin
        state_d     = ST_HOLD;
        mem_we_d    = 1'b1;
        mem_wdata_d = packed_word;
      end else begin
        err_d = 1'b1;
        if (!err_q) err_op_d = in_opcode;
        if (err_cnt_q != CNT_MAX) err_cnt_d = err_cnt_q + CNT_W'(1);
      end
    end

    if (clear) begin
      state_d     = ST_IDLE;
      mem_we_d    = 1'b0;
      mem_addr_d  = '0;
      mem_wdata_d = '0;
      err_d       = 1'b0;
      err_op_d    = '0;
      err_cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      err_q       <= 1'b0;
      err_op_q    <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      err_q       <= err_d;
      err_op_q    <= err_op_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign full      = (state_q == ST_FULL);
  assign err       = err_q;
  assign err_op    = err_op_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_instr_word_packer.sv
// Scoreboard bench for instr_word_packer with a small IMEM (4 words) and a 3-bit reject counter.
module tb_instr_word_packer;

  localparam int AW = 2;
  localparam int CW = 3;
  localparam logic [AW-1:0] AMAX = '1;

  logic          clk = 1'b0;
  logic          rst, clear, in_valid, in_ready, mem_we, mem_ready, full, err;
  logic [3:0]    in_opcode, in_one, in_two, err_op;
  logic [15:0]   in_imm, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [CW-1:0] err_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  bit rdy_rand = 1'b0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [15:0]   word;
    logic [15:0]   imm;
    logic [3:0]    op;
  } exp_t;
  exp_t sb[$];

  bit            m_held = 0, m_full = 0, m_err = 0;
  logic [AW-1:0] m_addr = '0;
  logic [3:0]    m_err_op = '0;
  int            m_err_cnt = 0;

  instr_word_packer #(.ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_one(in_one), .in_two(in_two), .in_imm(in_imm),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .full(full), .err(err), .err_op(err_op), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Immediate field width by opcode class; 0 means unchecked (R type).
  function automatic int imm_w(input logic [3:0] op);
    case (op)
      4'h8, 4'hB:       return 4;
      4'h4, 4'h5, 4'h6: return 8;
      4'hC, 4'hF:       return 12;
      default:          return 0;
    endcase
  endfunction

  function automatic logic [15:0] pack(input logic [3:0] op, input logic [3:0] one,
                                       input logic [3:0] two, input logic [15:0] imm);
    case (imm_w(op))
      8:       return {op, one, imm[7:0]};
      12:      return {op, imm[11:0]};
      default: return {op, one, two, imm[3:0]};
    endcase
  endfunction

  task automatic m_reset();
    m_held = 0; m_full = 0; m_err = 0; m_addr = '0; m_err_op = '0; m_err_cnt = 0;
  endtask

  // Reference model: checks observable state and pushes expected writes on every accept.
  initial forever begin : model
    logic exp_rdy;
    int   w, v;
    exp_t e;
    @(negedge clk);
    if (rst) begin
      if (m_held) void'(sb.pop_back());
      m_reset();
    end
    chk("mem_we", mem_we, m_held);
    chk("mem_addr", mem_addr, m_addr);
    chk("full", full, m_full);
    chk("err", err, m_err);
    chk("err_op", err_op, m_err_op);
    chk("err_cnt", err_cnt, m_err_cnt);
    if (!rst) begin
      exp_rdy = !clear && !m_full && (!m_held || (mem_ready && m_addr != AMAX));
      chk("in_ready", in_ready, exp_rdy);
      if (clear) begin
        if (m_held && !mem_ready) void'(sb.pop_back());
        m_reset();
      end else begin
        if (m_held && mem_ready) begin
          m_held = 0;
          if (m_addr == AMAX) m_full = 1;
          else m_addr = m_addr + 1'b1;
        end
        if (in_valid && exp_rdy) begin
          w = imm_w(in_opcode);
          v = int'($signed(in_imm));
          if (w == 0 || (v >= -(1 << (w - 1)) && v < (1 << (w - 1)))) begin
            e.addr = m_addr; e.word = pack(in_opcode, in_one, in_two, in_imm);
            e.imm = in_imm; e.op = in_opcode;
            sb.push_back(e);
            m_held = 1;
          end else begin
            if (!m_err) m_err_op = in_opcode;
            m_err = 1;
            if (m_err_cnt < (1 << CW) - 1) m_err_cnt++;
          end
        end
      end
    end
  end

  // Monitor: every completed IMEM write must match the oldest expected word.
  initial forever begin : monitor
    exp_t e;
    int   w, f;
    @(negedge clk);
    if (!rst && mem_we && mem_ready) begin
      if (sb.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL spurious_write: addr=%0d data=0x%0h, expected no write", mem_addr, mem_wdata);
      end else begin
        e = sb.pop_front();
        chk("wr_addr", mem_addr, e.addr);
        chk("wr_data", mem_wdata, e.word);
        w = imm_w(e.op);
        if (w != 0) begin
          f = int'(mem_wdata) & ((1 << w) - 1);
          if (f >= (1 << (w - 1))) f -= (1 << w);
          chk("sext_imm", f, int'($signed(e.imm)));
        end
      end
    end
  end

  initial forever begin : rdy_gen
    @(posedge clk); #1;
    if (rdy_rand) mem_ready = ($urandom_range(0, 2) != 0);
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step(1);
    clear = 1'b0;
  endtask

  // Offer one request and hold it until accepted; gives up quietly if the memory fills.
  task automatic send(input logic [3:0] op, input logic [3:0] one, input logic [3:0] two,
                      input logic [15:0] imm);
    int n = 0;
    in_valid = 1'b1; in_opcode = op; in_one = one; in_two = two; in_imm = imm;
    @(negedge clk);
    while (!in_ready && !full && n < 200) begin @(negedge clk); n++; end
    if (!in_ready && !full) begin
      n_fail++;
      $display("FAIL send_timeout: in_ready=0 after %0d cycles, expected 1", n);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin : stim
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; mem_ready = 1'b1;
    in_opcode = '0; in_one = '0; in_two = '0; in_imm = '0;
    @(negedge clk);
    chk("reset_we", mem_we, 0);
    chk("reset_wdata", mem_wdata, 0);
    step(1);
    rst = 1'b0;
    step(1);

    send(4'h8, 4'h3, 4'h5, 16'hFFFD);
    @(negedge clk);
    chk("t1_we", mem_we, 1);
    chk("t1_wdata", mem_wdata, 16'h835D);
    chk("t1_addr", mem_addr, 0);
    step(1);

    send(4'h4, 4'h2, 4'h0, 16'd127);
    @(negedge clk);
    chk("t2_wdata", mem_wdata, 16'h427F);
    step(1);
    send(4'h4, 4'h2, 4'h0, 16'd128);
    @(negedge clk);
    chk("t2_err", err, 1);
    chk("t2_err_op", err_op, 4);
    chk("t2_err_cnt", err_cnt, 1);
    chk("t2_no_write", mem_we, 0);
    step(1);

    mem_ready = 1'b0;
    send(4'hC, 4'h0, 4'h0, 16'hF800);
    repeat (3) begin
      @(negedge clk);
      chk("t3_hold_we", mem_we, 1);
      chk("t3_hold_wdata", mem_wdata, 16'hC800);
      chk("t3_hold_addr", mem_addr, 2);
      chk("t3_in_ready", in_ready, 0);
      step(1);
    end
    mem_ready = 1'b1;
    @(negedge clk);
    chk("t3_write", mem_we, 1);
    step(1);
    @(negedge clk);
    chk("t3_done", mem_we, 0);
    step(1);

    do_clear();
    @(negedge clk);
    chk("clr_addr", mem_addr, 0);
    chk("clr_err", err, 0);
    step(1);

    for (int i = 0; i < 4; i++) send(4'(i), 4'($urandom), 4'($urandom), 16'($urandom));
    step(2);
    @(negedge clk);
    chk("t5_full", full, 1);
    chk("t5_in_ready", in_ready, 0);
    chk("t5_addr", mem_addr, 3);
    step(1);
    do_clear();
    @(negedge clk);
    chk("t5_clr_full", full, 0);
    chk("t5_clr_addr", mem_addr, 0);
    step(1);

    for (int i = 0; i < 9; i++) send(4'h8, 4'h0, 4'h0, 16'd100);
    @(negedge clk);
    chk("sat_err_cnt", err_cnt, 7);
    chk("sat_err_op", err_op, 8);
    step(1);

    send(4'h4, 4'h1, 4'h1, 16'd5);
    step(1);
    mem_ready = 1'b0;
    send(4'h4, 4'h1, 4'h1, 16'd6);
    rst = 1'b1;
    #1;
    chk("t6_rst_we", mem_we, 0);
    chk("t6_rst_addr", mem_addr, 0);
    step(1);
    rst = 1'b0;
    mem_ready = 1'b1;
    step(1);
    clear = 1'b1; in_valid = 1'b1; in_opcode = 4'h4; in_one = 4'h1; in_imm = 16'd9;
    @(negedge clk);
    chk("t6_clr_rdy", in_ready, 0);
    step(1);
    clear = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("t6_clr_nowr", mem_we, 0);
    step(1);

    rdy_rand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (full) begin
        do_clear();
      end else if ($urandom_range(0, 40) == 0) begin
        do_clear();
      end else begin
        logic [15:0] imm;
        int r;
        case ($urandom_range(0, 3))
          0:       r = int'($urandom_range(0, 65535));
          1:       r = int'($urandom_range(0, 31)) - 16;
          2:       r = int'($urandom_range(0, 599)) - 300;
          default: r = int'($urandom_range(0, 4199)) - 2100;
        endcase
        imm = r[15:0];
        if ($urandom_range(0, 3) == 0) step(1);
        send(4'($urandom), 4'($urandom), 4'($urandom), imm);
      end
    end
    rdy_rand = 1'b0;
    mem_ready = 1'b1;
    step(6);
    chk("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
